// File: rtl/uart_ctrl.sv
// 8N1 UART responder for the memory-stage strobes: wrn loads a byte for transmit,
// received frames raise data_ready and are presented on rdata while rdn is low.
module uart_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       uarti_clk,
  input  logic       uarti_rst,
  input  logic       uarti_wrn,
  input  logic       uarti_rdn,
  input  logic [7:0] uarti_wdata,
  output logic [7:0] uarto_rdata,
  output logic       uarto_rdata_oe,
  output logic       uarto_data_ready,
  output logic       uarto_tbre,
  output logic       uarto_tsre,
  output logic       uarto_overrun,
  output logic       uarto_frame_err,
  input  logic       uarti_rx,
  output logic       uarto_tx
);

  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LASTIX = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic wrn_q, rdn_q, wr_evt, rd_evt;
  logic rx_s1_q, rx_s2_q, rx_s3_q, rxs;

  tx_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_sr_q, tx_sr_d, tx_hr_q, tx_hr_d;
  logic        tbre_q, tbre_d, tsre_q, tsre_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rdata_q, rdata_d;
  logic        dr_q, dr_d, ovr_q, ovr_d, fe_q, fe_d;

  // Edge events compare the live strobe against last cycle's sample.
  assign wr_evt = wrn_q & ~uarti_wrn;
  assign rd_evt = ~rdn_q & uarti_rdn;
  assign rxs    = rx_s2_q;

  always_ff @(posedge uarti_clk or negedge uarti_rst) begin
    if (!uarti_rst) begin
      wrn_q   <= 1'b1;
      rdn_q   <= 1'b1;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      wrn_q   <= uarti_wrn;
      rdn_q   <= uarti_rdn;
      rx_s1_q <= uarti_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  always_ff @(posedge uarti_clk or negedge uarti_rst) begin
    if (!uarti_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sr_q    <= '0;
      tx_hr_q    <= '0;
      tbre_q     <= 1'b1;
      tsre_q     <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sr_q    <= tx_sr_d;
      tx_hr_q    <= tx_hr_d;
      tbre_q     <= tbre_d;
      tsre_q     <= tsre_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sr_d    = tx_sr_q;
    tx_hr_d    = tx_hr_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    if (wr_evt && tbre_q) begin
      tx_hr_d = uarti_wdata;
      tbre_d  = 1'b0;
    end
    unique case (tx_state_q)
      TX_IDLE: if (!tbre_q) begin
        tx_sr_d    = tx_hr_q;
        tbre_d     = 1'b1;
        tsre_d     = 1'b0;
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == LAST) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_DATA: if (tx_cnt_q == LAST) begin
        tx_cnt_d = '0;
        if (tx_idx_q == LASTIX) tx_state_d = TX_STOP;
        else tx_idx_d = tx_idx_q + 1'b1;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_STOP: if (tx_cnt_q == LAST) begin
        tx_cnt_d = '0;
        // A pending holding byte chains straight into the next start bit.
        if (!tbre_q) begin
          tx_sr_d    = tx_hr_q;
          tbre_d     = 1'b1;
          tx_state_d = TX_START;
        end else begin
          tsre_d     = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge uarti_clk or negedge uarti_rst) begin
    if (!uarti_rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rdata_q    <= '0;
      dr_q       <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rdata_q    <= rdata_d;
      dr_q       <= dr_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rdata_d    = rdata_q;
    dr_d       = dr_q;
    ovr_d      = ovr_q;
    fe_d       = fe_q;
    if (rd_evt) begin
      dr_d  = 1'b0;
      ovr_d = 1'b0;
      fe_d  = 1'b0;
    end
    unique case (rx_state_q)
      RX_IDLE: if (rx_s3_q && !rxs) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == MID) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rxs ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_DATA: if (rx_cnt_q == LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rxs, rx_sh_q[7:1]};
        if (rx_idx_q == LASTIX) rx_state_d = RX_STOP;
        else rx_idx_d = rx_idx_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_STOP: if (rx_cnt_q == LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        // A new byte landing on the read-complete cycle is not an overrun.
        if (rxs) begin
          rdata_d = rx_sh_q;
          dr_d    = 1'b1;
          if (dr_q && !rd_evt) ovr_d = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      TX_START: uarto_tx = 1'b0;
      TX_DATA:  uarto_tx = tx_sr_q[tx_idx_q];
      default:  uarto_tx = 1'b1;
    endcase
  end

  assign uarto_rdata      = rdata_q;
  assign uarto_rdata_oe   = ~uarti_rdn;
  assign uarto_data_ready = dr_q;
  assign uarto_tbre       = tbre_q;
  assign uarto_tsre       = tsre_q;
  assign uarto_overrun    = ovr_q;
  assign uarto_frame_err  = fe_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a short bit period; expected values are hand-computed constants.
module tb_uart_ctrl;

  localparam int unsigned C = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrn = 1'b1;
  logic       rdn = 1'b1;
  logic [7:0] wdata = '0;
  logic       rx = 1'b1;
  logic [7:0] rdata;
  logic       rdata_oe, data_ready, tbre, tsre, overrun, frame_err, tx;

  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .uarti_clk        (clk),
    .uarti_rst        (rst),
    .uarti_wrn        (wrn),
    .uarti_rdn        (rdn),
    .uarti_wdata      (wdata),
    .uarto_rdata      (rdata),
    .uarto_rdata_oe   (rdata_oe),
    .uarto_data_ready (data_ready),
    .uarto_tbre       (tbre),
    .uarto_tsre       (tsre),
    .uarto_overrun    (overrun),
    .uarto_frame_err  (frame_err),
    .uarti_rx         (rx),
    .uarto_tx         (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Three clocks: event edge, load edge, then strobe released.
  task automatic do_write(input logic [7:0] b);
    wrn = 1'b0;
    wdata = b;
    tick();
    tick();
    wrn = 1'b1;
    tick();
  endtask

  task automatic capture(input int unsigned to_mid, output logic [7:0] b,
                         output logic st, output logic sb);
    repeat (to_mid) tick();
    st = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (C) tick();
      b[i] = tx;
    end
    repeat (C) tick();
    sb = tx;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) tick();
    end
    rx = stopb;
    repeat (C) tick();
    rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic do_read();
    rdn = 1'b0;
    tick();
    rdn = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] b;
    logic st, sb, lvl;
    int unsigned n;

    #2 rst = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_tbre", tbre, 1);
    check("rst_tsre", tsre, 1);
    check("rst_dr", data_ready, 0);
    check("rst_ovr", overrun, 0);
    check("rst_fe", frame_err, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_oe", rdata_oe, 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // 1: single byte 0x55, every level exactly one bit period
    wrn = 1'b0;
    wdata = 8'h55;
    tick();
    check("t1_tbre_fall", tbre, 0);
    check("t1_tsre_hold", tsre, 1);
    tick();
    check("t1_tbre_back", tbre, 1);
    check("t1_tsre_fall", tsre, 0);
    check("t1_tx_start", tx, 0);
    wrn = 1'b1;
    lvl = 1'b0;
    for (int l = 0; l < 9; l++) begin
      n = 0;
      while (tx === lvl && n < 2 * C) begin
        n++;
        tick();
      end
      check("t1_len", n, C);
      lvl = ~lvl;
    end
    n = 0;
    while (tx === 1'b1 && n < C) begin
      n++;
      tick();
    end
    check("t1_stop_len", n, C);
    check("t1_tsre_end", tsre, 1);

    // 2: back-to-back frames, third write dropped
    repeat (4) tick();
    do_write(8'hA3);
    do_write(8'h0F);
    check("t2_tbre_full", tbre, 0);
    do_write(8'h77);
    check("t2_tbre_still", tbre, 0);
    capture(C / 2 - 8, b, st, sb);
    check("t2_f1_start", st, 0);
    check("t2_f1_byte", b, 8'hA3);
    check("t2_f1_stop", sb, 1);
    repeat (C / 2) tick();
    check("t2_stop_last", tx, 1);
    tick();
    check("t2_no_gap", tx, 0);
    capture(C / 2 - 1, b, st, sb);
    check("t2_f2_start", st, 0);
    check("t2_f2_byte", b, 8'h0F);
    check("t2_f2_stop", sb, 1);
    n = 0;
    repeat (3 * C) begin
      tick();
      if (tx !== 1'b1) n++;
    end
    check("t2_no_third", n, 0);
    check("t2_tsre_end", tsre, 1);
    check("t2_tbre_end", tbre, 1);

    // 3: receive 0x3C and read it
    send_rx(8'h3C, 1'b1);
    check("t3_dr", data_ready, 1);
    check("t3_rdata", rdata, 8'h3C);
    check("t3_oe_idle", rdata_oe, 0);
    rdn = 1'b0;
    #1;
    check("t3_oe", rdata_oe, 1);
    repeat (3) tick();
    check("t3_dr_hold", data_ready, 1);
    rdn = 1'b1;
    tick();
    check("t3_dr_clr", data_ready, 0);
    check("t3_rdata_keep", rdata, 8'h3C);

    // 4: overrun
    send_rx(8'h11, 1'b1);
    check("t4_ovr_first", overrun, 0);
    send_rx(8'h22, 1'b1);
    check("t4_rdata", rdata, 8'h22);
    check("t4_dr", data_ready, 1);
    check("t4_ovr", overrun, 1);
    do_read();
    check("t4_ovr_clr", overrun, 0);
    check("t4_dr_clr", data_ready, 0);

    // 5: framing error, then short glitch, then a good frame
    send_rx(8'h5A, 1'b0);
    check("t5_fe", frame_err, 1);
    check("t5_dr", data_ready, 0);
    check("t5_rdata", rdata, 8'h22);
    do_read();
    check("t5_fe_clr", frame_err, 0);
    rx = 1'b0;
    repeat (6) tick();
    rx = 1'b1;
    repeat (12 * C) tick();
    check("t5_glitch_dr", data_ready, 0);
    check("t5_glitch_fe", frame_err, 0);
    send_rx(8'h81, 1'b1);
    check("t5_after_dr", data_ready, 1);
    check("t5_after_rdata", rdata, 8'h81);

    // 6: reset in the middle of data bit 4 on both paths
    do_write(8'hC6);
    rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (C) tick();
    end
    rx = 1'b0;
    repeat (C / 2) tick();
    check("t6_pre_tx_busy", tsre, 0);
    rst = 1'b0;
    rx = 1'b1;
    #1;
    check("t6_tx", tx, 1);
    check("t6_tbre", tbre, 1);
    check("t6_tsre", tsre, 1);
    check("t6_dr", data_ready, 0);
    check("t6_ovr", overrun, 0);
    check("t6_fe", frame_err, 0);
    check("t6_rdata", rdata, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    repeat (2 * C) tick();
    do_write(8'h3A);
    capture(C / 2 - 2, b, st, sb);
    check("t6_tx_start", st, 0);
    check("t6_tx_byte", b, 8'h3A);
    check("t6_tx_stop", sb, 1);
    repeat (2 * C) tick();
    send_rx(8'hE7, 1'b1);
    check("t6_rx_dr", data_ready, 1);
    check("t6_rx_byte", rdata, 8'hE7);
    check("t6_rx_fe", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Serial-port responder on the far side of the CPU's memory-stage UART strobes (wrn/rdn, data_ready, writeable).
- Accepts a byte on a wrn strobe and serializes it 8N1 on a TX line.
- Deserializes 8N1 frames from an RX line, raises data_ready, and presents the byte while rdn is low.
- Replaces the external UART chip. Both sides run on the single 50 MHz system clock.

Parameters:
CLKS_PER_BIT, 5208, system clocks per bit period (50 MHz / 9600 baud); must be >= 4
DATA_BITS, 8, data bits per frame; fixed at 8, not user-varied

Ports:
uarti_clk  input  1  system clock, 50 MHz, all logic on rising edge
uarti_rst  input  1  asynchronous active-low reset
uarti_wrn  input  1  write strobe, active low, from memory stage
uarti_rdn  input  1  read strobe, active low, from memory stage
uarti_wdata  input  8  byte to transmit; valid while wrn low
uarto_rdata  output  8  received byte; valid while rdata_oe high
uarto_rdata_oe  output  1  high while rdn low; drives the shared data bus
uarto_data_ready  output  1  unread received byte available
uarto_tbre  output  1  transmit holding register empty
uarto_tsre  output  1  transmit shift register empty (line idle)
uarto_overrun  output  1  sticky: a received byte overwrote an unread byte
uarto_frame_err  output  1  sticky: a frame ended with stop bit = 0
uarti_rx  input  1  serial input line, idle high, asynchronous
uarto_tx  output  1  serial output line, idle high

Behaviour:
Reset values:
- tx=1, tbre=1, tsre=1, data_ready=0, overrun=0, frame_err=0, rdata=0, rdata_oe=0.
- Both FSMs go to IDLE and all counters clear.
- Asserting reset mid-frame aborts the frame immediately; tx returns to 1 within 0 cycles (async).

Strobe sampling:
- wrn and rdn are registered once per clock.
- A write event is the sampled transition 1->0 of wrn; one event per strobe however long wrn stays low.
- A read-complete event is the sampled transition 0->1 of rdn.
- rdata_oe = ~uarti_rdn, combinational. rdata always drives the last valid received byte.

TX path (holding register HR, shift register SR, FSM TX_IDLE/TX_START/TX_DATA/TX_STOP):
- Write event with tbre=1: HR<=wdata, tbre<=0 on that edge.
- Write event with tbre=0: the byte is dropped; no state change.
- TX_IDLE with tbre=0: next cycle SR<=HR, tbre<=1, tsre<=0, state TX_START.
- Back-to-back bytes: HR can be reloaded while SR shifts.
- TX_START: tx=0 for CLKS_PER_BIT clocks.
- TX_DATA: 8 bits, LSB first, CLKS_PER_BIT clocks each; a 3-bit index counts them.
- TX_STOP: tx=1 for CLKS_PER_BIT clocks.
- At end of TX_STOP: if tbre=0, load HR into SR and go to TX_START with no idle gap; otherwise go to TX_IDLE with tsre<=1.
- Writeable for the CPU is tbre & tsre.

RX path (FSM RX_IDLE/RX_START/RX_DATA/RX_STOP):
- rx passes through a 2-FF synchronizer; the sampled value is rxs.
- RX_IDLE: falling edge on rxs moves to RX_START and clears the bit counter.
- RX_START: at CLKS_PER_BIT/2, if rxs=1 it is a glitch and the FSM returns to RX_IDLE; otherwise it moves to RX_DATA.
- RX_DATA: sample at each subsequent CLKS_PER_BIT, shifting in LSB first, 8 samples.
- RX_STOP: sample one bit period later.
  - rxs=1: rdata<=byte and data_ready<=1. If data_ready was already 1, overrun<=1 as well.
  - rxs=0: frame_err<=1; byte discarded; rdata and data_ready unchanged.
  - Either way, return to RX_IDLE, re-arming for the next falling edge.
- Read-complete event: data_ready<=0, overrun<=0, frame_err<=0.
- Simultaneous read-complete and valid stop bit in the same cycle: the new byte wins. data_ready=1, rdata=new byte, overrun=0.
- rdn low for multiple cycles has no effect until its rising edge.

Counters:
- Bit-timer width is clog2(CLKS_PER_BIT).
- Counters wrap to 0 at CLKS_PER_BIT-1.

Test Plan:
1. Reset, then write event wdata=0x55.
   - tbre falls on the next edge and tsre falls one cycle later.
   - tx shows 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each level 5208 clocks.
   - tsre=1 afterwards.
2. Write 0xA3 then 0x0F while the first is shifting.
   - Second frame starts immediately after the first stop bit, no idle gap.
   - A third write while tbre=0 is dropped; only 2 frames appear.
3. Drive rx with frame 0x3C at 9600 baud.
   - data_ready=1 after the stop sample; rdata=0x3C.
   - With rdn low, rdata_oe=1; on the rdn rising edge, data_ready=0.
4. Two frames, 0x11 then 0x22, with no read in between -> rdata=0x22, data_ready=1, overrun=1; overrun clears on read-complete.
5. Frame with stop bit=0 -> frame_err=1, data_ready unchanged; a 1000-clock low glitch on rx -> no byte received, FSM back in RX_IDLE.
6. Assert reset mid-TX data bit 4 and mid-RX data bit 4 -> tx=1 immediately; all outputs at reset values; the next full frame in each direction works correctly.
